ic_refill_ctrl: RTL and testbench

- Write-side controller for the instruction-cache tag and data RAMs.
- On a miss it invalidates the target line's tag and issues one burst read to the memory side. It writes each returned word into the data RAM, then writes the valid tag entry.
- It also runs a full-cache flush that walks every line and writes an invalid tag entry.
- It sits between the cache lookup pipeline (miss source) and the tag/data RAM write ports.

---
 rtl/ic_pkg.sv | 26 ++
 rtl/ic_flush_walker.sv | 29 ++
 rtl/ic_refill_ctrl.sv | 150 +++++++++++++++
 tb/tb_ic_refill_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// rtl/ic_pkg.sv - shared types and geometry for the instruction-cache refill path
package ic_pkg;
  localparam int LINES  = 256;
  localparam int WORDS  = 4;
  localparam int LINE_W = 8;
  localparam int WORD_W = 2;
  localparam int TAG_W  = 15;

  typedef logic [LINE_W-1:0] ic_line_t;
  typedef logic [TAG_W-1:0]  ic_tag_t;
  typedef logic [WORD_W-1:0] ic_word_t;

  typedef struct packed {
    logic    valid;
    ic_tag_t tag;
  } ic_tag_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INV,
    ST_REQ,
    ST_FILL,
    ST_TAG,
    ST_FLUSH
  } refill_state_t;
endpackage

// File: rtl/ic_flush_walker.sv
// rtl/ic_flush_walker.sv - line counter for the full-cache tag flush
module ic_flush_walker
  import ic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [LINE_W-1:0] index,
  output logic              done
);

  // done marks the cycle carrying the last line, so busy lasts exactly LINES cycles
  assign done = busy && (index == ic_line_t'(LINES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      index <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      index <= '0;
    end else if (busy) begin
      index <= index + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ic_refill_ctrl.sv
// rtl/ic_refill_ctrl.sv - icache miss refill and flush controller
// Optional critical-word-first ordering under IC_REFILL_CRITICAL_WORD_FIRST_EN.
module ic_refill_ctrl
  import ic_pkg::*;
#(
  parameter int ADDR_W = TAG_W + LINE_W + WORD_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [LINE_W-1:0] miss_line,
  input  logic [TAG_W-1:0]  miss_tag,
  input  logic [WORD_W-1:0] miss_word,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              data_wr_en,
  output logic [LINE_W-1:0] data_wr_line,
  output logic [WORD_W-1:0] data_wr_word,
  output logic [31:0]       data_wr_data,
  output logic              tag_wr_en,
  output logic [LINE_W-1:0] tag_wr_line,
  output logic [15:0]       tag_wr_data,
  output logic              refill_done,
  output logic              refill_err
);

  refill_state_t state_q, state_d;
  ic_line_t      line_q;
  ic_tag_t       tag_q;
  ic_word_t      word_q;
  ic_word_t      beat_q;
  logic          err_q;
  ic_word_t      start_word;
  logic          miss_fire, flush_start, last_beat, err_now;
  logic          walk_done;
  ic_line_t      walk_index;

`ifdef IC_REFILL_CRITICAL_WORD_FIRST_EN
  assign start_word = miss_word;
`else
  logic unused_miss_word;
  assign unused_miss_word = ^miss_word;
  assign start_word       = '0;
`endif

  assign miss_ready   = (state_q == ST_IDLE) && !flush_req;
  assign miss_fire    = miss_valid && miss_ready;
  assign flush_start  = (state_q == ST_IDLE) && flush_req;
  assign last_beat    = (state_q == ST_FILL) && mem_rsp_valid && (beat_q == ic_word_t'(WORDS - 1));
  assign err_now      = err_q | mem_rsp_err;
  assign mem_req_addr = ADDR_W'({tag_q, line_q, word_q, 2'b00});

  ic_flush_walker u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .start (flush_start),
    .busy  (flush_busy),
    .index (walk_index),
    .done  (walk_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      tag_q   <= '0;
      word_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_fire) begin
        line_q <= miss_line;
        tag_q  <= miss_tag;
        word_q <= start_word;
      end
      if (state_q == ST_REQ && mem_req_ready) begin
        beat_q <= '0;
        err_q  <= 1'b0;
      end else if (state_q == ST_FILL && mem_rsp_valid) begin
        beat_q <= beat_q + 1'b1;
        err_q  <= last_beat ? 1'b0 : err_now;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    data_wr_en    = 1'b0;
    data_wr_line  = '0;
    data_wr_word  = '0;
    data_wr_data  = '0;
    tag_wr_en     = 1'b0;
    tag_wr_line   = '0;
    tag_wr_data   = '0;
    refill_done   = 1'b0;
    refill_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_req)       state_d = ST_FLUSH;
        else if (miss_valid) state_d = ST_INV;
      end
      ST_INV: begin
        // invalidate first so lookups never hit a half-filled line
        tag_wr_en   = 1'b1;
        tag_wr_line = line_q;
        tag_wr_data = ic_tag_entry_t'{valid: 1'b0, tag: tag_q};
        state_d     = ST_REQ;
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (mem_rsp_valid) begin
          data_wr_en   = 1'b1;
          data_wr_line = line_q;
          data_wr_word = word_q + beat_q;
          data_wr_data = mem_rsp_data;
        end
        if (last_beat) begin
          refill_err = err_now;
          state_d    = err_now ? ST_IDLE : ST_TAG;
        end
      end
      ST_TAG: begin
        tag_wr_en   = 1'b1;
        tag_wr_line = line_q;
        tag_wr_data = ic_tag_entry_t'{valid: 1'b1, tag: tag_q};
        refill_done = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_FLUSH: begin
        tag_wr_en   = 1'b1;
        tag_wr_line = walk_index;
        if (walk_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ic_refill_ctrl.sv
// tb/tb_ic_refill_ctrl.sv - scoreboard bench for ic_refill_ctrl
module tb_ic_refill_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_valid = 1'b0, miss_ready;
  logic [7:0]  miss_line = '0;
  logic [14:0] miss_tag = '0;
  logic [1:0]  miss_word = '0;
  logic        flush_req = 1'b0, flush_busy;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [26:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        data_wr_en, tag_wr_en, refill_done, refill_err;
  logic [7:0]  data_wr_line, tag_wr_line;
  logic [1:0]  data_wr_word;
  logic [31:0] data_wr_data;
  logic [15:0] tag_wr_data;

  ic_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_line(miss_line),
    .miss_tag(miss_tag), .miss_word(miss_word),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .data_wr_en(data_wr_en), .data_wr_line(data_wr_line), .data_wr_word(data_wr_word),
    .data_wr_data(data_wr_data),
    .tag_wr_en(tag_wr_en), .tag_wr_line(tag_wr_line), .tag_wr_data(tag_wr_data),
    .refill_done(refill_done), .refill_err(refill_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, hs_cyc = 0, done_cyc = 0;
  int done_cnt = 0, err_cnt = 0, busy_cnt = 0, busy_ready_viol = 0;
  logic [41:0] dq[$];
  logic [23:0] tq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RAM write the DUT makes must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_wr_en) begin
        if (dq.size() == 0) chk("data_unexpected", data_wr_en, 1'b0);
        else chk("data_wr", {data_wr_line, data_wr_word, data_wr_data}, dq.pop_front());
      end
      if (tag_wr_en) begin
        if (tq.size() == 0) chk("tag_unexpected", tag_wr_en, 1'b0);
        else chk("tag_wr", {tag_wr_line, tag_wr_data}, tq.pop_front());
      end
      if (refill_done) begin done_cnt++; done_cyc = cyc; end
      if (refill_err) err_cnt++;
      if (flush_busy) begin
        busy_cnt++;
        if (miss_ready) busy_ready_viol++;
      end
    end
  end

  function automatic logic [1:0] start_of(input logic [1:0] w);
`ifdef IC_REFILL_CRITICAL_WORD_FIRST_EN
    return w;
`else
    return 2'd0;
`endif
  endfunction

  task automatic push_miss(input logic [7:0] line, input logic [14:0] tag, input logic [1:0] w,
                           input logic [31:0] base, input bit err);
    logic [1:0] s;
    s = start_of(w);
    tq.push_back({line, 1'b0, tag});
    for (int i = 0; i < 4; i++) dq.push_back({line, 2'(s + 2'(i)), base + 32'(i)});
    if (!err) tq.push_back({line, 1'b1, tag});
  endtask

  task automatic do_miss(input logic [7:0] line, input logic [14:0] tag, input logic [1:0] w);
    bit ok;
    miss_valid = 1'b1; miss_line = line; miss_tag = tag; miss_word = w;
    ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (miss_ready) ok = 1;
    end
    if (!ok) chk("miss_timeout", miss_ready, 1'b1);
    hs_cyc = cyc;
    @(posedge clk); #1;
    miss_valid = 1'b0;
  endtask

  task automatic serve_req(input logic [26:0] addr, input int stall);
    bit ok;
    mem_req_ready = 1'b0;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (mem_req_valid) ok = 1;
    end
    if (!ok) chk("req_timeout", mem_req_valid, 1'b1);
    chk("req_addr", mem_req_addr, addr);
    repeat (stall) begin
      @(negedge clk);
      chk("req_stall_hold", {mem_req_valid, mem_req_addr}, {1'b1, addr});
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
  endtask

  task automatic beats(input logic [31:0] base, input int gap, input int err_beat);
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = base + 32'(i);
      mem_rsp_err   = (i == err_beat);
      if (i == 3 && err_beat >= 0) begin
        @(negedge clk);
        chk("err_pulse", refill_err, 1'b1);
      end
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      if (i < 3) begin
        repeat (gap) begin
          @(negedge clk);
          chk("gap_no_write", data_wr_en, 1'b0);
          @(posedge clk); #1;
        end
      end
    end
    if (err_beat >= 0) begin
      @(negedge clk);
      chk("ready_after_err", miss_ready, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_ok(input int prev_done);
    @(negedge clk);
    @(posedge clk); #1;
    chk("done_count", 32'(done_cnt), 32'(prev_done + 1));
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("tq_drained", 32'(tq.size()), 32'd0);
  endtask

  initial begin
    int pd, pe;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {miss_ready, flush_busy, mem_req_valid, data_wr_en, tag_wr_en, refill_done, refill_err},
        7'b1000000);
    chk("reset_addr", mem_req_addr, 27'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic zero-wait refill
    pd = done_cnt;
    push_miss(8'h3C, 15'h1234, 2'd0, 32'hA0, 0);
    do_miss(8'h3C, 15'h1234, 2'd0);
    serve_req({15'h1234, 8'h3C, 2'd0, 2'b00}, 0);
    beats(32'hA0, 0, -1);
    finish_ok(pd);
    chk("latency", 32'(done_cyc - hs_cyc), 32'd7);

    // error on beat 2: all data writes, no valid tag
    pd = done_cnt; pe = err_cnt;
    push_miss(8'h11, 15'h0555, 2'd0, 32'hB0, 1);
    do_miss(8'h11, 15'h0555, 2'd0);
    serve_req({15'h0555, 8'h11, 2'd0, 2'b00}, 0);
    beats(32'hB0, 0, 2);
    repeat (2) @(posedge clk); #1;
    chk("err_count", 32'(err_cnt), 32'(pe + 1));
    chk("err_no_done", 32'(done_cnt), 32'(pd));
    chk("err_tq_drained", 32'(tq.size()), 32'd0);

    // flush walk
    busy_cnt = 0; busy_ready_viol = 0;
    for (int i = 0; i < 256; i++) tq.push_back({8'(i), 16'h0000});
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (262) @(posedge clk); #1;
    chk("flush_busy_cycles", 32'(busy_cnt), 32'd256);
    chk("flush_ready_low", 32'(busy_ready_viol), 32'd0);
    chk("flush_tq_drained", 32'(tq.size()), 32'd0);
    chk("flush_ended", {flush_busy, miss_ready}, 2'b01);

    // flush and miss in the same IDLE cycle: flush first
    pd = done_cnt;
    for (int i = 0; i < 256; i++) tq.push_back({8'(i), 16'h0000});
    push_miss(8'h22, 15'h7FFF, 2'd0, 32'hC0, 0);
    flush_req = 1'b1; miss_valid = 1'b1; miss_line = 8'h22; miss_tag = 15'h7FFF;
    @(negedge clk);
    chk("sim_ready_low", miss_ready, 1'b0);
    @(posedge clk); #1;
    flush_req = 1'b0;
    do_miss(8'h22, 15'h7FFF, 2'd0);
    serve_req({15'h7FFF, 8'h22, 2'd0, 2'b00}, 0);
    beats(32'hC0, 0, -1);
    finish_ok(pd);

    // request backpressure and gaps between beats
    pd = done_cnt;
    push_miss(8'hFF, 15'h0001, 2'd0, 32'hD0, 0);
    do_miss(8'hFF, 15'h0001, 2'd0);
    serve_req({15'h0001, 8'hFF, 2'd0, 2'b00}, 4);
    beats(32'hD0, 3, -1);
    finish_ok(pd);

    // critical word offset 2
    pd = done_cnt;
    push_miss(8'h5A, 15'h2AAA, 2'd2, 32'hE0, 0);
    do_miss(8'h5A, 15'h2AAA, 2'd2);
    serve_req({15'h2AAA, 8'h5A, start_of(2'd2), 2'b00}, 0);
    beats(32'hE0, 1, -1);
    finish_ok(pd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
